sipo_shift_reg: RTL and testbench

//  Parametrised serial-in/parallel-out shift register with built-in tick prescaler.

---
 rtl/sipo_shift_reg.sv | 126 ++++++++++++
 tb/tb_sipo_shift_reg.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in/parallel-out shift register with a built-in tick
// prescaler. Samples d_i once per prescaler tick, assembles WIDTH-bit words,
// and publishes each finished word on data_o with a one-cycle valid_o strobe.
// Optional feature macro: SERIAL_OUT_EN adds q_o, the oldest shift stage.
module sipo_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             d_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] shreg_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             tick_o
`ifdef SERIAL_OUT_EN
    ,
    output logic             q_o
`endif
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             tick_q;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             shift_en;
    logic             last_bit;

    // Prescaler next count: wraps at DIV-1.
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(DIV - 1)) begin
            cnt_nxt = '0;
        end
    end

    // Free-running prescaler. The tick is registered so it is high exactly
    // while cnt==DIV-1, and stays low during reset even for DIV=1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (clr_i) begin
            cnt    <= '0;
            tick_q <= (DIV == 1);
        end else begin
            cnt    <= cnt_nxt;
            tick_q <= (cnt_nxt == CW'(DIV - 1));
        end
    end

    // Next shift-register value, direction set by MSB_FIRST.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST != 0) begin
            shifted = {shreg[WIDTH-2:0], d_i};
        end else begin
            shifted = {d_i, shreg[WIDTH-1:1]};
        end
    end

    assign shift_en = tick_q & en_i & ~clr_i;
    assign last_bit = (bitcnt == BW'(WIDTH - 1));

    // Word assembly FSM: shifts on enabled ticks, publishes on the last bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (clr_i) begin
                shreg  <= '0;
                bitcnt <= '0;
                state  <= IDLE;
            end else if (shift_en) begin
                shreg <= shifted;
                case (state)
                    IDLE: begin
                        bitcnt <= BW'(1);
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            data_o  <= shifted;
                            valid_o <= 1'b1;
                            bitcnt  <= '0;
                            state   <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    default: begin
                        bitcnt <= '0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign shreg_o = shreg;
    assign tick_o  = tick_q;

`ifdef SERIAL_OUT_EN
    assign q_o = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
`endif

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Bench for sipo_shift_reg: three instances (8/4/MSB, 8/4/LSB, 4/1/MSB)
// checked every cycle against a bit-history reference model, plus directed
// word tables and hand-written enable/clear/reset/serial-out sequences.
module tb_sipo_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, d, en, clr;
    logic [7:0] sh0, dt0, sh1, dt1;
    logic [3:0] sh2, dt2;
    logic       v0, v1, v2, t0, t1, t2;
`ifdef SERIAL_OUT_EN
    logic       q0, q1, q2;
`endif

    sipo_shift_reg #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u0 (
        .clk_i(clk), .rst_i(rst_n), .d_i(d), .en_i(en), .clr_i(clr),
        .shreg_o(sh0), .data_o(dt0), .valid_o(v0), .tick_o(t0)
`ifdef SERIAL_OUT_EN
        , .q_o(q0)
`endif
    );

    sipo_shift_reg #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) u1 (
        .clk_i(clk), .rst_i(rst_n), .d_i(d), .en_i(en), .clr_i(clr),
        .shreg_o(sh1), .data_o(dt1), .valid_o(v1), .tick_o(t1)
`ifdef SERIAL_OUT_EN
        , .q_o(q1)
`endif
    );

    sipo_shift_reg #(.WIDTH(4), .DIV(1), .MSB_FIRST(1)) u2 (
        .clk_i(clk), .rst_i(rst_n), .d_i(d), .en_i(en), .clr_i(clr),
        .shreg_o(sh2), .data_o(dt2), .valid_o(v2), .tick_o(t2)
`ifdef SERIAL_OUT_EN
        , .q_o(q2)
`endif
    );

    localparam int unsigned P_W [3] = '{8, 8, 4};
    localparam int unsigned P_D [3] = '{4, 4, 1};
    localparam int unsigned P_M [3] = '{1, 0, 1};

    int n_chk  = 0;
    int n_pass = 0;
    int vpulse0 = 0;
    int vpulse1 = 0;

    // Reference model: every accepted bit since reset/clear is remembered;
    // register contents are the newest WIDTH bits placed by arrival order.
    int unsigned m_edges [3];
    int unsigned m_cyc   [3];
    int unsigned m_nacc  [3];
    int unsigned m_nw    [3];
    bit          m_acc   [3][4096];
    logic [7:0]  m_data  [3];
    bit          m_valid [3];

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_edges[i] = 0; m_cyc[i] = 0; m_nacc[i] = 0; m_nw[i] = 0;
            m_data[i] = '0; m_valid[i] = 1'b0;
        end
    endtask

    function automatic logic [7:0] m_shreg(input int i);
        logic [7:0] r;
        bit b;
        r = '0;
        for (int j = 0; j < int'(P_W[i]); j++) begin
            b = 1'b0;
            if (m_nacc[i] > j) b = m_acc[i][(m_nacc[i] - 1 - j) % 4096];
            if (P_M[i] != 0) r[j] = b;
            else             r[P_W[i] - 1 - j] = b;
        end
        return r;
    endfunction

    function automatic bit m_tick(input int i);
        if (P_D[i] == 1) return (m_edges[i] >= 1);
        return ((m_cyc[i] % P_D[i]) == P_D[i] - 1);
    endfunction

    task automatic m_edge(input bit dd, input bit ee, input bit cc);
        bit tk;
        for (int i = 0; i < 3; i++) begin
            tk = m_tick(i);
            m_valid[i] = 1'b0;
            if (cc) begin
                m_nacc[i] = 0; m_nw[i] = 0; m_cyc[i] = 0;
            end else begin
                if (tk && ee) begin
                    m_acc[i][m_nacc[i] % 4096] = dd;
                    m_nacc[i]++;
                    m_nw[i]++;
                    if (m_nw[i] == P_W[i]) begin
                        m_data[i]  = m_shreg(i);
                        m_valid[i] = 1'b1;
                        m_nw[i]    = 0;
                    end
                end
                m_cyc[i]++;
            end
            m_edges[i]++;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_all();
        logic [7:0] s;
        chk("u0_shreg", sh0, m_shreg(0));
        chk("u0_data",  dt0, m_data[0]);
        chk("u0_valid", {7'b0, v0}, {7'b0, m_valid[0]});
        chk("u0_tick",  {7'b0, t0}, {7'b0, m_tick(0)});
        chk("u1_shreg", sh1, m_shreg(1));
        chk("u1_data",  dt1, m_data[1]);
        chk("u1_valid", {7'b0, v1}, {7'b0, m_valid[1]});
        chk("u1_tick",  {7'b0, t1}, {7'b0, m_tick(1)});
        chk("u2_shreg", {4'b0, sh2}, m_shreg(2));
        chk("u2_data",  {4'b0, dt2}, m_data[2]);
        chk("u2_valid", {7'b0, v2}, {7'b0, m_valid[2]});
        chk("u2_tick",  {7'b0, t2}, {7'b0, m_tick(2)});
`ifdef SERIAL_OUT_EN
        s = m_shreg(0); chk("u0_q", {7'b0, q0}, {7'b0, s[7]});
        s = m_shreg(1); chk("u1_q", {7'b0, q1}, {7'b0, s[0]});
        s = m_shreg(2); chk("u2_q", {7'b0, q2}, {7'b0, s[3]});
`endif
        vpulse0 += int'(v0);
        vpulse1 += int'(v1);
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one.
    task automatic step(input bit dd, input bit ee, input bit cc);
        d = dd; en = ee; clr = cc;
        @(posedge clk);
        m_edge(dd, ee, cc);
        @(negedge clk);
        check_all();
    endtask

    // Waits (bounded) for a tick of the DIV=4 instances and shifts one bit in on it.
    task automatic send_bit(input bit b, input bit c);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            if (m_tick(0)) begin
                step(b, 1'b1, c);
                done = 1'b1;
            end else begin
                step(1'($urandom % 2), 1'b1, 1'b0);
            end
        end
        if (!done) chk("tick_wait", 8'd0, 8'd1);
    endtask

    typedef struct {
        logic [7:0] bits;      // bits[7] is sent first
        bit         clr_last;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
        bit         exp_valid;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cnt;
        int k;
        logic [7:0] b4;

        tbl[0] = '{8'b10100101, 1'b0, 8'hA5, 8'hA5, 1'b1};
        tbl[1] = '{8'b11000000, 1'b0, 8'hC0, 8'h03, 1'b1};
        tbl[2] = '{8'b00000001, 1'b0, 8'h01, 8'h80, 1'b1};
        tbl[3] = '{8'b11111111, 1'b1, 8'h01, 8'h80, 1'b0};
        tbl[4] = '{8'b11110000, 1'b0, 8'hF0, 8'h0F, 1'b1};

        rst_n = 1'b0; d = 1'b0; en = 1'b0; clr = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Tick period: 4 ticks in 16 cycles on the DIV=4 instance.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0);
            cnt += int'(t0);
        end
        chk("tick_period", 8'(cnt), 8'd4);
        step(1'b0, 1'b1, 1'b1);

        // Directed words, including a clear on the final bit.
        for (int r = 0; r < 5; r++) begin
            b4 = tbl[r].bits;
            for (int j = 7; j >= 0; j--) begin
                send_bit(b4[j], tbl[r].clr_last && (j == 0));
            end
            chk("tbl_data_msb", dt0, tbl[r].exp_msb);
            chk("tbl_data_lsb", dt1, tbl[r].exp_lsb);
            chk("tbl_valid_msb", {7'b0, v0}, {7'b0, tbl[r].exp_valid});
            chk("tbl_valid_lsb", {7'b0, v1}, {7'b0, tbl[r].exp_valid});
        end

        // Enable dropped for 10 cycles after three bits of word 10110011.
        vpulse0 = 0; vpulse1 = 0;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom % 2), 1'b0, 1'b0);
            chk("frozen_msb", sh0, 8'h85);
            chk("frozen_lsb", sh1, 8'hA1);
        end
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_msb", dt0, 8'hB3);
        chk("resume_lsb", dt1, 8'hCD);
        chk("resume_pulses_msb", 8'(vpulse0), 8'd1);
        chk("resume_pulses_lsb", 8'(vpulse1), 8'd1);

        // Asynchronous reset in the middle of a word.
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_shreg", sh0, 8'h00);
        chk("arst_data",  dt0, 8'h00);
        chk("arst_vt",    {6'b0, v0, t0}, 8'h00);
        chk("arst_u2",    {dt2, sh2}, 8'h00);
        chk("arst_u2_t",  {7'b0, t2}, 8'h00);
        m_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        k = 0;
        while (k < 8 && !t0) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        chk("first_tick", 8'(k), 8'd3);

`ifdef SERIAL_OUT_EN
        // Single-cycle pulse through the 4-stage DIV=1 delay line.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("q_delay", {7'b0, q2}, {7'b0, (i == 3)});
        end
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom % 2), ($urandom % 10) < 7, ($urandom % 25) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
